// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline buffer.
package pipe_pkg;

  localparam int PIPE_DEPTH_MIN = 2;
  localparam int PIPE_DEPTH_MAX = 16;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Depth must be a power of two in range so pointers wrap naturally.
  function automatic bit depth_legal(input int depth);
    return (depth >= PIPE_DEPTH_MIN) && (depth <= PIPE_DEPTH_MAX) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// One buffer per stage boundary; fields are concatenated into the payload by the caller.
`define PIPE_BUF(name, w, d, clk, rst, flush, iv, id, ir, ov, od, ordy, cnt) pipe_buf #(.DATA_WIDTH(w), .DEPTH(d)) name (.clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(iv), .in_data_i(id), .in_ready_o(ir), .out_valid_o(ov), .out_data_o(od), .out_ready_i(ordy), .count_o(cnt));

// File: rtl/pipe_buf_mem.sv
// Storage array for pipe_buf: one write port, one asynchronous read port.
module pipe_buf_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port; storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipe_buf.sv
// Elastic valid/ready buffer between two pipeline stages with flush and occupancy.
// in_ready_o is derived from registered occupancy only, never from out_ready_i.
module pipe_buf
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic [CNT_W-1:0]      count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("pipe_buf: DEPTH must be a power of two in %0d..%0d", PIPE_DEPTH_MIN, PIPE_DEPTH_MAX);
  end
  if (CNT_W != cnt_width(DEPTH)) begin : g_bad_cnt_w
    $error("pipe_buf: CNT_W is derived from DEPTH and must not be overridden");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign in_ready_o  = (count_q != CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign count_o     = count_q;

  // Next pointers and occupancy; flush drops everything including this cycle's transfers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  pipe_buf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push & ~flush_i & ~rst_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data_o)
  );

`ifndef SYNTHESIS
  logic                  hold_q;
  logic [DATA_WIDTH-1:0] hold_data_q;

  // Remember whether the head was stalled at the last edge, and what it showed.
  always_ff @(posedge clk_i) begin
    hold_q      <= !rst_i && !flush_i && out_valid_o && !out_ready_i;
    hold_data_q <= out_data_o;
  end

  // Occupancy bounds and stalled-head stability.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (count_q <= CNT_W'(DEPTH))
        else $error("pipe_buf: count %0d exceeds DEPTH %0d", count_q, DEPTH);
    end
    if (hold_q) begin
      assert (out_data_o == hold_data_q)
        else $error("pipe_buf: head data changed while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_pipe_buf.sv
// Directed and random checks of pipe_buf at depths 2, 4, 8 and 16 against a queue model.
module tb_pipe_buf;

  localparam int NINST = 4;
  localparam int DEPTHS [NINST] = '{2, 4, 8, 16};

  logic        clk;
  logic        rst       [NINST];
  logic        flush     [NINST];
  logic        in_valid  [NINST];
  logic [31:0] in_data   [NINST];
  logic        in_ready  [NINST];
  logic        out_valid [NINST];
  logic [31:0] out_data  [NINST];
  logic        out_ready [NINST];
  logic [4:0]  cnt       [NINST];

  int errors = 0;
  int checks = 0;

  logic [31:0] mq [NINST][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam int D = DEPTHS[g];
    logic [$clog2(D+1)-1:0] cnt_raw;
    pipe_buf #(.DATA_WIDTH(32), .DEPTH(D)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst[g]),
      .flush_i     (flush[g]),
      .in_valid_i  (in_valid[g]),
      .in_data_i   (in_data[g]),
      .in_ready_o  (in_ready[g]),
      .out_valid_o (out_valid[g]),
      .out_data_o  (out_data[g]),
      .out_ready_i (out_ready[g]),
      .count_o     (cnt_raw)
    );
    assign cnt[g] = 5'(cnt_raw);
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[D=%0d]: observed=%h expected=%h", tag, DEPTHS[k], obs, exp);
    end
  endtask

  // One clock cycle on instance k: drive, compare against model, clock, update model.
  task automatic cycle(input int k, input logic v, input logic [31:0] d, input logic r,
                       input logic fl, input logic rs, output logic acc);
    int  sz;
    bit  push, pop;
    in_valid[k]  = v;
    in_data[k]   = d;
    out_ready[k] = r;
    flush[k]     = fl;
    rst[k]       = rs;
    #1;
    sz = mq[k].size();
    chk("out_valid", k, 32'(out_valid[k]), 32'(sz != 0));
    chk("in_ready",  k, 32'(in_ready[k]),  32'(sz < DEPTHS[k]));
    chk("count",     k, 32'(cnt[k]),       32'(sz));
    if (sz != 0) chk("out_data", k, out_data[k], mq[k][0]);
    push = v && (sz < DEPTHS[k]);
    pop  = r && (sz != 0);
    acc  = push && !fl && !rs;
    @(posedge clk);
    if (rs || fl) begin
      mq[k].delete();
    end else begin
      if (pop)  void'(mq[k].pop_front());
      if (push) mq[k].push_back(d);
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
    flush[k]    = 1'b0;
    rst[k]      = 1'b0;
  endtask

  initial begin
    logic acc;
    int   tries;
    for (int i = 0; i < NINST; i++) begin
      rst[i] = 1'b1; flush[i] = 1'b0; in_valid[i] = 1'b0;
      in_data[i] = '0; out_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NINST; i++) rst[i] = 1'b0;

    // Reset state of every instance.
    for (int i = 0; i < NINST; i++) cycle(i, 1'b0, '0, 1'b0, 1'b0, 1'b0, acc);

    // Stream through DEPTH=2 with downstream always ready.
    for (int i = 0; i < 8; i++) cycle(0, 1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0, acc);
    repeat (2) cycle(0, 1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Fill DEPTH=4 with downstream stalled; 0xA4 must be refused.
    for (int i = 0; i < 5; i++) cycle(1, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0, acc);
    chk("a4_refused", 1, 32'(acc), 32'd0);
    repeat (2) cycle(1, 1'b1, 32'hA4, 1'b0, 1'b0, 1'b0, acc);

    // Drain: 0xA4 is accepted only after the first pop has freed an entry.
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 10) begin
      cycle(1, 1'b1, 32'hA4, 1'b1, 1'b0, 1'b0, acc);
      tries++;
    end
    chk("a4_accept_cycle", 1, 32'(tries), 32'd2);
    repeat (6) cycle(1, 1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Flush with a same-cycle push; 0x44 must vanish, 0x55 is next out.
    cycle(1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, acc);
    cycle(1, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0, acc);
    cycle(1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b0, acc);
    cycle(1, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, acc);
    cycle(1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, acc);
    repeat (3) cycle(1, 1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Reset DEPTH=8 while holding five entries.
    for (int i = 0; i < 5; i++) cycle(2, 1'b1, $urandom, 1'b0, 1'b0, 1'b0, acc);
    cycle(2, 1'b1, 32'h99, 1'b1, 1'b0, 1'b1, acc);
    cycle(2, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0, acc);
    repeat (3) cycle(2, 1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Random valid/ready on DEPTH=16.
    for (int i = 0; i < 10000; i++) begin
      cycle(3, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, acc);
    end
    repeat (20) cycle(3, 1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("final_empty", 3, 32'(out_valid[3]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
